// File: rtl/mips_boot_loader_pkg.sv
// Shared definitions for the MIPS boot loader: FSM state encoding,
// stream word size and the default memory address width.
package mips_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_ADDR = 3'd1,
    S_HDR_CNT  = 3'd2,
    S_LOAD     = 3'd3,
    S_CHECK    = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  // Header fields and payload words share the same 4-byte framing.
  localparam int WORD_BYTES = 4;
  localparam int ADDR_W_DEF = 10;

endpackage

// File: rtl/mips_boot_loader_packer.sv
// Byte-to-word packer: collects big-endian bytes into 32-bit words.
// word_valid/word are combinational and present in the cycle the 4th byte
// of a word is accepted, so the loader can register the write directly.
module mips_boot_loader_packer
  import mips_boot_loader_pkg::*;
(
  input  logic        clk1,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // Byte counter and shift register; start discards any partial word.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (accept) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[15:0], in_byte};
    end
  end

  assign word_valid = accept && (cnt == 2'(WORD_BYTES - 1));
  assign word       = {shift, in_byte};

endmodule

// File: rtl/mips_boot_loader.sv
// Byte-stream program loader for pipe_MIPS32. Frame:
//   ADDR (4 B) | COUNT (4 B) | COUNT words [| CHECKSUM (4 B)]
// The trailing checksum word exists only when BOOT_CHECKSUM_EN is defined.
//
// state      | meaning
// S_IDLE     | after reset, waiting for start
// S_HDR_ADDR | collecting the 4-byte load address
// S_HDR_CNT  | collecting the 4-byte word count
// S_LOAD     | collecting payload words, one memory write per word
// S_CHECK    | collecting and comparing the checksum word
// S_DONE     | image loaded, CPU released
// S_ERR      | session aborted (oversized count or checksum mismatch)
module mips_boot_loader
  import mips_boot_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic [31:0]       cpu_pc_init,
  output logic              busy,
  output logic              err
);

  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W:0]   remaining;
  logic              accept;
  logic              start_ok;
  logic              word_valid;
  logic [31:0]       word;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       sum;
`endif

  assign busy     = (state inside {S_HDR_ADDR, S_HDR_CNT, S_LOAD, S_CHECK});
  // The drain cycle after the last word (remaining==0 in LOAD) takes no byte.
  assign in_ready = busy && !(state == S_LOAD && remaining == '0);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && (state inside {S_IDLE, S_DONE, S_ERR});

  mips_boot_loader_packer u_packer (
    .clk1       (clk1),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (accept),
    .in_byte    (in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_nx = S_HDR_ADDR;
      S_HDR_ADDR: if (word_valid) state_nx = S_HDR_CNT;
      S_HDR_CNT: begin
        if (word_valid) begin
          if (word > DEPTH)      state_nx = S_ERR;
`ifdef BOOT_CHECKSUM_EN
          else if (word == '0)   state_nx = S_CHECK;
`else
          else if (word == '0)   state_nx = S_DONE;
`endif
          else                   state_nx = S_LOAD;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_LOAD: if (word_valid && remaining == (ADDR_W+1)'(1)) state_nx = S_CHECK;
      S_CHECK: begin
        if (word_valid) state_nx = (word == sum) ? S_DONE : S_ERR;
      end
`else
      // Leave LOAD only once the last write strobe is on the port.
      S_LOAD: if (remaining == '0) state_nx = S_DONE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Header capture, write port, word counter and status outputs.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      base_addr   <= '0;
      addr_ptr    <= '0;
      remaining   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_run     <= 1'b0;
      cpu_pc_init <= '0;
      err         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        cpu_run <= 1'b0;
        err     <= 1'b0;
      end
      if (state == S_HDR_ADDR && word_valid) begin
        base_addr <= word[ADDR_W-1:0];
        addr_ptr  <= word[ADDR_W-1:0];
      end
      if (state == S_HDR_CNT && word_valid) begin
        remaining <= word[ADDR_W:0];
`ifdef BOOT_CHECKSUM_EN
        sum       <= '0;
`endif
      end
      if (state == S_LOAD && word_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr_ptr;
        mem_wdata <= word;
        addr_ptr  <= addr_ptr + 1'b1;
        remaining <= remaining - 1'b1;
`ifdef BOOT_CHECKSUM_EN
        sum       <= sum + word;
`endif
      end
      if (state_nx == S_DONE && state != S_DONE) begin
        cpu_run     <= 1'b1;
        cpu_pc_init <= 32'(base_addr);
      end
      if (state_nx == S_ERR && state != S_ERR) err <= 1'b1;
    end
  end

endmodule
